range_session_arbiter: RTL and testbench
========================================

Name: range_session_arbiter

Overview:
- Round-robin scheduler that shares one range-finder datapath (go/finish/data_in, range/error) among NREQ sample-stream requesters.
- Grants one requester per session and converts its valid/ready sample stream into the finder's contiguous go…finish sequence.
- Returns the session's range tagged with the requester id.
- Sits between the stream sources and a single range-finder instance; both blocks share clock and reset.

Parameters:
- WIDTH, 8, sample and range width.
- NREQ, 4, number of requesters (≥2).
- MAX_GAP, 15, consecutive idle stream cycles tolerated before the session is aborted.

Ports:
- clock  in  1  clock.
- reset  in  1  reset; asynchronous, active-high.
- req_valid  in  NREQ  per-requester sample valid.
- req_data  in  NREQ*WIDTH  flattened samples; requester i occupies bits [i*WIDTH +: WIDTH].
- req_last  in  NREQ  marks the final sample of a requester's burst.
- req_ready  out  NREQ  per-requester accept, combinational, one-hot or zero.
- rf_data  out  WIDTH  sample to the finder.
- rf_go  out  1  finder go.
- rf_finish  out  1  finder finish.
- rf_range  in  WIDTH  finder range result.
- rf_error  in  1  finder error flag.
- resp_valid  out  1  one-cycle result strobe.
- resp_id  out  $clog2(NREQ)  requester the result belongs to.
- resp_range  out  WIDTH  session range.
- resp_error  out  1  session aborted or finder error seen.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Transfer rule: a transfer occurs when req_valid[i] & req_ready[i].
- Reset (async): state IDLE; hold, grant, gap_cnt, abort, err_seen cleared; rr_last = NREQ-1 so requester 0 has first priority; all outputs 0.
- Moore outputs: rf_data = hold register in every state; rf_go = (state==GO); rf_finish = (state==FIN). rf_go and rf_finish are never high together.
- IDLE:
  - Pick the first valid requester scanning from (rr_last+1) mod NREQ upward with wrap; drive req_ready only for the picked requester.
  - On transfer: hold<=sample, grant<=i, single<=req_last[i], clear abort/err_seen/gap_cnt, go to GO.
- GO:
  - If single: req_ready=0, go to FIN.
  - Else req_ready[grant]=1. Transfer: hold<=sample; go to FIN if last, else STREAM. No transfer: go to STREAM and count 1 gap.
- STREAM:
  - req_ready[grant]=1.
  - Transfer: hold<=sample, gap_cnt<=0; go to FIN if last.
  - No transfer: gap_cnt+1. The sample is replayed; replay cannot change min/max. When the count reaches MAX_GAP: abort<=1, go to FIN.
- FIN: single cycle, req_ready=0; the finder latches its range on this edge. Go to CAP.
- CAP:
  - resp_range<=rf_range, resp_id<=grant, resp_error<=abort|err_seen|rf_error, resp_valid<=1 (registered).
  - rr_last<=grant; go to IDLE.
- resp_valid is high exactly one cycle: the IDLE cycle after CAP, which may coincide with the next session's first transfer. resp_* hold their values until the next CAP.
- err_seen is set on any rf_error from GO through FIN.
- Latency: with finish shown in cycle F, resp_valid is high in cycle F+2. The earliest next rf_go is F+3, which guarantees the finder is back in START.
- Requesters not granted see req_ready=0 for the whole session; their valid/data are ignored.
- A single-sample burst yields range 0 with no finder error (go and finish are never simultaneous).
- Reset mid-session: outputs drop to 0 immediately; no resp_valid is produced for the killed session.

Test Plan:
- Req0 bursts 10,50,3,27(last) back-to-back from reset -> one rf_go cycle with rf_data=10; rf_finish with rf_data=27; resp_valid 2 cycles later with resp_id=0, resp_range=47, resp_error=0.
- Req2 sends single sample 99 with last -> GO then FIN, both rf_data=99; resp_range=0, resp_id=2, resp_error=0; req_ready[2] high for exactly one cycle.
- Req1 sends 20, stalls 5 cycles, then 80(last) -> rf_data holds 20 during the gap, go/finish low; resp_range=60, resp_error=0.
- Req1 and req2 hold valid with 2-sample bursts continuously -> grants alternate 1,2,1,2; never two req_ready bits high; next rf_go no earlier than 3 cycles after each rf_finish.
- Req0 sends 5, then drops valid for 20 cycles -> FIN after the 15th idle STREAM cycle; resp_error=1, resp_range=0; req0's later samples start a new session.
- Reset asserted mid-STREAM between clock edges -> busy, rf_go, rf_finish, req_ready and resp_valid are 0 immediately; after release, req0 burst 7,9(last) -> resp_range=2, resp_id=0.

Source files
------------

// File: rtl/range_session_arbiter.sv
// Round-robin scheduler that turns one granted requester's valid/ready sample
// stream into a contiguous go..finish session on a shared range finder.
module range_session_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NREQ    = 4,
  parameter int MAX_GAP = 15
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*WIDTH-1:0]     req_data,
  input  logic [NREQ-1:0]           req_last,
  output logic [NREQ-1:0]           req_ready,
  output logic [WIDTH-1:0]          rf_data,
  output logic                      rf_go,
  output logic                      rf_finish,
  input  logic [WIDTH-1:0]          rf_range,
  input  logic                      rf_error,
  output logic                      resp_valid,
  output logic [$clog2(NREQ)-1:0]   resp_id,
  output logic [WIDTH-1:0]          resp_range,
  output logic                      resp_error,
  output logic                      busy
);

  localparam int IDW  = $clog2(NREQ);
  localparam int GAPW = $clog2(MAX_GAP + 1);

  typedef enum logic [2:0] {IDLE, GO, STREAM, FIN, CAP} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] hold_q;
  logic [IDW-1:0]   grant_q;
  logic [IDW-1:0]   rrLast_q;
  logic             single_q;
  logic             abort_q;
  logic             errSeen_q;
  logic [GAPW-1:0]  gap_q;
  logic             respValid_q;
  logic             respError_q;
  logic [IDW-1:0]   respId_q;
  logic [WIDTH-1:0] respRange_q;

  logic             pickValid;
  logic [IDW-1:0]   pickIdx;
  logic [IDW-1:0]   scanIdx;
  logic [IDW-1:0]   srcIdx;
  logic [NREQ-1:0]  readyInt;
  logic             xfer;
  logic             srcLast;
  logic [WIDTH-1:0] srcData;

  // Scan starts just after the requester served last, so every waiter gets a turn.
  always_comb begin
    pickValid = 1'b0;
    pickIdx   = '0;
    scanIdx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      scanIdx = IDW'((int'(rrLast_q) + k) % NREQ);
      if (!pickValid && req_valid[scanIdx]) begin
        pickValid = 1'b1;
        pickIdx   = scanIdx;
      end
    end
  end

  always_comb begin
    readyInt = '0;
    case (state_q)
      IDLE:    if (pickValid) readyInt[pickIdx] = 1'b1;
      GO:      if (!single_q) readyInt[grant_q] = 1'b1;
      STREAM:  readyInt[grant_q] = 1'b1;
      default: ;
    endcase
  end

  assign srcIdx  = (state_q == IDLE) ? pickIdx : grant_q;
  assign srcData = req_data[int'(srcIdx)*WIDTH +: WIDTH];
  assign srcLast = req_last[srcIdx];
  assign xfer    = |(req_valid & readyInt);

  // Gated so a requester never sees an accept while the block is held in reset.
  assign req_ready  = readyInt & {NREQ{~reset}};
  assign rf_data    = hold_q;
  assign rf_go      = (state_q == GO);
  assign rf_finish  = (state_q == FIN);
  assign busy       = (state_q != IDLE);
  assign resp_valid = respValid_q;
  assign resp_id    = respId_q;
  assign resp_range = respRange_q;
  assign resp_error = respError_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      grant_q     <= '0;
      rrLast_q    <= IDW'(NREQ - 1);
      single_q    <= 1'b0;
      abort_q     <= 1'b0;
      errSeen_q   <= 1'b0;
      gap_q       <= '0;
      respValid_q <= 1'b0;
      respError_q <= 1'b0;
      respId_q    <= '0;
      respRange_q <= '0;
    end else begin
      respValid_q <= 1'b0;
      if ((state_q == GO || state_q == STREAM || state_q == FIN) && rf_error)
        errSeen_q <= 1'b1;
      case (state_q)
        IDLE: if (xfer) begin
          hold_q    <= srcData;
          grant_q   <= pickIdx;
          single_q  <= srcLast;
          abort_q   <= 1'b0;
          errSeen_q <= 1'b0;
          gap_q     <= '0;
          state_q   <= GO;
        end
        GO: begin
          if (single_q) begin
            state_q <= FIN;
          end else if (xfer) begin
            hold_q  <= srcData;
            state_q <= srcLast ? FIN : STREAM;
          end else begin
            gap_q   <= GAPW'(1);
            state_q <= STREAM;
          end
        end
        // An idle cycle replays the held sample, which cannot move min/max.
        STREAM: begin
          if (xfer) begin
            hold_q <= srcData;
            gap_q  <= '0;
            if (srcLast) state_q <= FIN;
          end else if (gap_q == GAPW'(MAX_GAP - 1)) begin
            abort_q <= 1'b1;
            state_q <= FIN;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        FIN: state_q <= CAP;
        CAP: begin
          respRange_q <= rf_range;
          respId_q    <= grant_q;
          respError_q <= abort_q | errSeen_q | rf_error;
          respValid_q <= 1'b1;
          rrLast_q    <= grant_q;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_range_session_arbiter.sv
// Directed bench for range_session_arbiter with a behavioural min/max range finder.
module tb_range_session_arbiter;

  localparam int WIDTH   = 8;
  localparam int NREQ    = 4;
  localparam int MAX_GAP = 15;
  localparam int IDW     = 2;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       reqValid;
  logic [NREQ*WIDTH-1:0] reqData;
  logic [NREQ-1:0]       reqLast;
  logic [NREQ-1:0]       reqReady;
  logic [WIDTH-1:0]      rfData;
  logic                  rfGo;
  logic                  rfFinish;
  logic [WIDTH-1:0]      rfRange;
  logic                  rfError;
  logic                  respValid;
  logic [IDW-1:0]        respId;
  logic [WIDTH-1:0]      respRange;
  logic                  respError;
  logic                  busy;

  int checks = 0;
  int errors = 0;

  range_session_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .MAX_GAP(MAX_GAP)) dut (
    .clock(clock), .reset(reset),
    .req_valid(reqValid), .req_data(reqData), .req_last(reqLast), .req_ready(reqReady),
    .rf_data(rfData), .rf_go(rfGo), .rf_finish(rfFinish),
    .rf_range(rfRange), .rf_error(rfError),
    .resp_valid(respValid), .resp_id(respId), .resp_range(respRange),
    .resp_error(respError), .busy(busy)
  );

  always #5 clock = ~clock;

  // Range finder: starts on go, tracks min/max every session cycle, latches on finish.
  logic [WIDTH-1:0] fMin, fMax, fLo, fHi;
  logic             fActive;
  assign fLo = (rfData < fMin) ? rfData : fMin;
  assign fHi = (rfData > fMax) ? rfData : fMax;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      fActive <= 1'b0; fMin <= '0; fMax <= '0; rfRange <= '0;
    end else if (rfGo) begin
      fActive <= 1'b1; fMin <= rfData; fMax <= rfData;
    end else if (fActive) begin
      fMin <= fLo; fMax <= fHi;
      if (rfFinish) begin
        rfRange <= fHi - fLo;
        fActive <= 1'b0;
      end
    end
  end

  // Mid-cycle monitor recording session events and protocol violations.
  int cyc = 0;
  int nGo = 0, nFin = 0, nResp = 0, lastGoCyc = 0, lastFinCyc = 0;
  int ohViol = 0, bothViol = 0, earlyGo = 0;
  int readyCnt [NREQ] = '{default: 0};
  logic [WIDTH-1:0] goData = '0, finData = '0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if ($countones(reqReady) > 1) ohViol <= ohViol + 1;
    if (rfGo && rfFinish) bothViol <= bothViol + 1;
    for (int i = 0; i < NREQ; i++) if (reqReady[i]) readyCnt[i] <= readyCnt[i] + 1;
    if (respValid) nResp <= nResp + 1;
    if (rfGo) begin
      if (nFin > 0 && cyc - lastFinCyc < 3) earlyGo <= earlyGo + 1;
      nGo <= nGo + 1; goData <= rfData; lastGoCyc <= cyc;
    end
    if (rfFinish) begin
      nFin <= nFin + 1; finData <= rfData; lastFinCyc <= cyc;
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic drive(input int id, input logic v, input logic [WIDTH-1:0] d, input logic l);
    reqValid[id] = v;
    reqData[id*WIDTH +: WIDTH] = d;
    reqLast[id] = l;
  endtask

  // Presents one sample and holds it until accepted; returns one cycle after the transfer.
  task automatic send(input int id, input logic [WIDTH-1:0] d, input logic l);
    int n = 0;
    logic done = 1'b0;
    drive(id, 1'b1, d, l);
    while (!done && n < 40) begin
      #1;
      if (reqReady[id]) done = 1'b1;
      @(posedge clock); #1;
      n++;
    end
    drive(id, 1'b0, '0, 1'b0);
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL send_accept req%0d: got no ready, expected accept within 40 cycles", id);
    end
  endtask

  task automatic waitResp(output int at);
    int n = 0;
    while (!respValid && n < 60) begin tick(); n++; end
    checks++;
    if (!respValid) begin
      errors++;
      $display("[TB] FAIL resp_timeout: got resp_valid=0, expected 1 within 60 cycles");
    end
    at = cyc;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #3;
    checks++;
    if ({busy, rfGo, rfFinish, respValid, respError} !== 5'b0 || reqReady !== '0 || rfData !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got busy=%b go=%b fin=%b rv=%b ready=%b data=%0d, expected all 0",
               busy, rfGo, rfFinish, respValid, reqReady, rfData);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || respId !== '0 || respRange !== '0) begin
      errors++;
      $display("[TB] FAIL reset_release: got busy=%b id=%0d range=%0d, expected 0 0 0", busy, respId, respRange);
    end
  endtask

  task automatic test_burst();
    int n0, at;
    n0 = nGo;
    send(0, 8'd10, 1'b0);
    send(0, 8'd50, 1'b0);
    send(0, 8'd3,  1'b0);
    send(0, 8'd27, 1'b1);
    waitResp(at);
    checks++;
    if (nGo - n0 !== 1 || goData !== 8'd10) begin
      errors++;
      $display("[TB] FAIL burst_go: got %0d go cycles data=%0d, expected 1 cycle data=10", nGo - n0, goData);
    end
    checks++;
    if (finData !== 8'd27 || lastFinCyc - lastGoCyc !== 3) begin
      errors++;
      $display("[TB] FAIL burst_finish: got data=%0d go-to-fin=%0d, expected 27 and 3", finData, lastFinCyc - lastGoCyc);
    end
    checks++;
    if (at - lastFinCyc !== 2) begin
      errors++;
      $display("[TB] FAIL burst_latency: got %0d cycles, expected 2", at - lastFinCyc);
    end
    checks++;
    if (respId !== 2'd0 || respRange !== 8'd47 || respError !== 1'b0) begin
      errors++;
      $display("[TB] FAIL burst_resp: got id=%0d range=%0d err=%b, expected 0 47 0", respId, respRange, respError);
    end
  endtask

  task automatic test_round_robin();
    int idx [NREQ];
    int ids [4];
    int rngs [4];
    logic [NREQ-1:0]  rdyPrev;
    logic [WIDTH-1:0] d;
    int nr, n, ohBase, bothBase, earlyBase, g0;
    idx = '{default: 0};
    ids = '{default: -1};
    rngs = '{default: -1};
    ohBase = ohViol; bothBase = bothViol; earlyBase = earlyGo; g0 = nGo;
    nr = 0; n = 0; rdyPrev = '0;
    tick();
    while (nr < 4 && n < 200) begin
      for (int r = 1; r <= 2; r++) if (rdyPrev[r]) idx[r]++;
      if (respValid) begin
        ids[nr] = int'(respId);
        rngs[nr] = int'(respRange);
        nr++;
      end
      if (nr < 4) begin
        for (int r = 1; r <= 2; r++) begin
          d = (idx[r] % 2 == 1) ? 8'(r*16 + r + 4) : 8'(r*16);
          drive(r, 1'b1, d, idx[r] % 2 == 1);
        end
        #1;
        rdyPrev = reqReady;
        tick();
      end
      n++;
    end
    drive(1, 1'b0, '0, 1'b0);
    drive(2, 1'b0, '0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ids[k] !== ((k % 2 == 0) ? 1 : 2) || rngs[k] !== ((k % 2 == 0) ? 5 : 6)) begin
        errors++;
        $display("[TB] FAIL rr_session%0d: got id=%0d range=%0d, expected id=%0d range=%0d",
                 k, ids[k], rngs[k], (k % 2 == 0) ? 1 : 2, (k % 2 == 0) ? 5 : 6);
      end
    end
    checks++;
    if (ohViol - ohBase !== 0 || bothViol - bothBase !== 0) begin
      errors++;
      $display("[TB] FAIL rr_onehot: got %0d multi-ready and %0d go+finish cycles, expected 0 and 0",
               ohViol - ohBase, bothViol - bothBase);
    end
    checks++;
    if (earlyGo - earlyBase !== 0 || nGo - g0 < 4) begin
      errors++;
      $display("[TB] FAIL rr_spacing: got %0d early go and %0d sessions, expected 0 early and at least 4",
               earlyGo - earlyBase, nGo - g0);
    end
  endtask

  task automatic test_single();
    int rc0, at;
    rc0 = readyCnt[2];
    send(2, 8'd99, 1'b1);
    checks++;
    if (rfGo !== 1'b1 || rfFinish !== 1'b0 || rfData !== 8'd99) begin
      errors++;
      $display("[TB] FAIL single_go: got go=%b fin=%b data=%0d, expected 1 0 99", rfGo, rfFinish, rfData);
    end
    tick();
    checks++;
    if (rfGo !== 1'b0 || rfFinish !== 1'b1 || rfData !== 8'd99) begin
      errors++;
      $display("[TB] FAIL single_fin: got go=%b fin=%b data=%0d, expected 0 1 99", rfGo, rfFinish, rfData);
    end
    waitResp(at);
    checks++;
    if (respId !== 2'd2 || respRange !== 8'd0 || respError !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_resp: got id=%0d range=%0d err=%b, expected 2 0 0", respId, respRange, respError);
    end
    checks++;
    if (readyCnt[2] - rc0 !== 1) begin
      errors++;
      $display("[TB] FAIL single_ready: got %0d ready cycles, expected 1", readyCnt[2] - rc0);
    end
  endtask

  task automatic test_gap();
    int at;
    send(1, 8'd20, 1'b0);
    checks++;
    if (rfGo !== 1'b1 || rfData !== 8'd20) begin
      errors++;
      $display("[TB] FAIL gap_go: got go=%b data=%0d, expected 1 20", rfGo, rfData);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (rfData !== 8'd20 || rfGo !== 1'b0 || rfFinish !== 1'b0) begin
        errors++;
        $display("[TB] FAIL gap_hold%0d: got data=%0d go=%b fin=%b, expected 20 0 0", k, rfData, rfGo, rfFinish);
      end
    end
    send(1, 8'd80, 1'b1);
    waitResp(at);
    checks++;
    if (respId !== 2'd1 || respRange !== 8'd60 || respError !== 1'b0) begin
      errors++;
      $display("[TB] FAIL gap_resp: got id=%0d range=%0d err=%b, expected 1 60 0", respId, respRange, respError);
    end
  endtask

  task automatic test_abort();
    int at;
    send(0, 8'd5, 1'b0);
    waitResp(at);
    checks++;
    if (respId !== 2'd0 || respRange !== 8'd0 || respError !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_resp: got id=%0d range=%0d err=%b, expected 0 0 1", respId, respRange, respError);
    end
    checks++;
    if (lastFinCyc - lastGoCyc < 15 || lastFinCyc - lastGoCyc > 16) begin
      errors++;
      $display("[TB] FAIL abort_timing: got go-to-fin=%0d, expected 15..16", lastFinCyc - lastGoCyc);
    end
    send(0, 8'd8, 1'b1);
    waitResp(at);
    checks++;
    if (goData !== 8'd8 || respId !== 2'd0 || respError !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_next: got go data=%0d id=%0d err=%b, expected 8 0 0", goData, respId, respError);
    end
  endtask

  task automatic test_reset_mid();
    int r0, at;
    send(0, 8'd1, 1'b0);
    send(0, 8'd2, 1'b0);
    drive(0, 1'b1, 8'd3, 1'b0);
    #2;
    r0 = nResp;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, rfGo, rfFinish, respValid} !== 4'b0 || reqReady !== '0 || rfData !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got busy=%b go=%b fin=%b rv=%b ready=%b data=%0d, expected all 0",
               busy, rfGo, rfFinish, respValid, reqReady, rfData);
    end
    drive(0, 1'b0, '0, 1'b0);
    #2;
    reset = 1'b0;
    tick();
    send(0, 8'd7, 1'b0);
    send(0, 8'd9, 1'b1);
    checks++;
    if (nResp !== r0) begin
      errors++;
      $display("[TB] FAIL midreset_noresp: got %0d responses, expected %0d", nResp, r0);
    end
    waitResp(at);
    checks++;
    if (respId !== 2'd0 || respRange !== 8'd2 || respError !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_resp: got id=%0d range=%0d err=%b, expected 0 2 0", respId, respRange, respError);
    end
  endtask

  initial begin
    reqValid = '0;
    reqData  = '0;
    reqLast  = '0;
    rfError  = 1'b0;
    reset    = 1'b1;
    test_reset();
    test_burst();
    test_round_robin();
    test_single();
    test_gap();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
